// File: rtl/accel_frame_packer.sv
// Assembles a burst of I2C bytes into NUM_BYTES/2 16-bit sample words behind a valid/ready handshake.
// Optional ACCEL_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module accel_frame_packer #(
    parameter int          NUM_BYTES   = 14,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4000,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        frame_abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp_raw,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        busy,
    output logic        frame_error,
    output logic        overrun
`ifdef ACCEL_OVERRUN_CNT_EN
    ,
    output logic [7:0]  overrun_cnt
`endif
);

    localparam int MAX_BYTES = 14;
    localparam int MAX_WORDS = 7;
    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  shadow_q [MAX_BYTES];
    logic [7:0]  shadow_d [MAX_BYTES];
    logic [15:0] words_q [MAX_WORDS];
    logic [15:0] words_d [MAX_WORDS];
    logic        sample_valid_q, sample_valid_d;
    logic        frame_error_q, frame_error_d;
    logic        overrun_q, overrun_d;
    logic        complete;
    logic        accept;
`ifdef ACCEL_OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt_q, overrun_cnt_d;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tmo_d          = tmo_q;
        shadow_d       = shadow_q;
        words_d        = words_q;
        sample_valid_d = sample_valid_q;
        frame_error_d  = 1'b0;
        overrun_d      = 1'b0;
        complete       = 1'b0;
        accept         = sample_valid_q && sample_ready;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                tmo_d = '0;
                if (frame_start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (frame_abort) begin
                    state_d       = IDLE;
                    frame_error_d = 1'b1;
                    idx_d         = '0;
                    tmo_d         = '0;
                end else if (frame_start) begin
                    frame_error_d = 1'b1;
                    idx_d         = '0;
                    tmo_d         = '0;
                end else if (tmo_q >= TIMEOUT_CYC) begin
                    state_d       = IDLE;
                    frame_error_d = 1'b1;
                    idx_d         = '0;
                    tmo_d         = '0;
                end else if (byte_valid) begin
                    tmo_d = '0;
                    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                        if (i == 32'(idx_q)) begin
                            shadow_d[i] = byte_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shadow slots beyond NUM_BYTES are never written, so unused words read back 0.
        if (complete) begin
            if (!sample_valid_q || accept) begin
                for (int unsigned w = 0; w < MAX_WORDS; w++) begin
                    words_d[w] = BIG_ENDIAN ? {shadow_d[2*w], shadow_d[2*w+1]}
                                            : {shadow_d[2*w+1], shadow_d[2*w]};
                end
                sample_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            sample_valid_d = 1'b0;
        end
    end

`ifdef ACCEL_OVERRUN_CNT_EN
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (overrun_d && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tmo_q          <= '0;
            shadow_q       <= '{default: '0};
            words_q        <= '{default: '0};
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef ACCEL_OVERRUN_CNT_EN
            overrun_cnt_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            shadow_q       <= shadow_d;
            words_q        <= words_d;
            sample_valid_q <= sample_valid_d;
            frame_error_q  <= frame_error_d;
            overrun_q      <= overrun_d;
`ifdef ACCEL_OVERRUN_CNT_EN
            overrun_cnt_q  <= overrun_cnt_d;
`endif
        end
    end

    assign sample_valid = sample_valid_q;
    assign accel_x      = words_q[0];
    assign accel_y      = words_q[1];
    assign accel_z      = words_q[2];
    assign temp_raw     = words_q[3];
    assign gyro_x       = words_q[4];
    assign gyro_y       = words_q[5];
    assign gyro_z       = words_q[6];
    assign busy         = (state_q == COLLECT);
    assign frame_error  = frame_error_q;
    assign overrun      = overrun_q;
`ifdef ACCEL_OVERRUN_CNT_EN
    assign overrun_cnt  = overrun_cnt_q;
`endif

endmodule
